// File: rtl/gfx_cmd_scheduler_if.sv
// Host-side command channel of the graphics command scheduler: valid/ready handshake
// plus the fill/blit operand fields carried with each command.
interface gfx_cmd_scheduler_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_op;
  logic       cmd_fill_value;
  logic [8:0] cmd_x1;
  logic [7:0] cmd_y1;
  logic [8:0] cmd_x2;
  logic [7:0] cmd_y2;
  logic [8:0] cmd_w;
  logic [7:0] cmd_h;

  modport master (
    output cmd_valid, cmd_op, cmd_fill_value,
    output cmd_x1, cmd_y1, cmd_x2, cmd_y2, cmd_w, cmd_h,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_fill_value,
    input  cmd_x1, cmd_y1, cmd_x2, cmd_y2, cmd_w, cmd_h,
    output cmd_ready
  );
endinterface

// File: rtl/gfx_cmd_scheduler.sv
// Queues fill/blit commands from the host registers and issues them one at a time to the
// graphics engine, holding the operands stable until the engine has finished.
module gfx_cmd_scheduler #(
  parameter int DEPTH       = 4,
  parameter int ADDR_W      = 2,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  gfx_cmd_scheduler_if.slave  cmd_if,
  input  logic                flush_i,
  input  logic                engine_busy_i,
  output logic                start_fill_o,
  output logic                start_blit_o,
  output logic                fill_value_o,
  output logic [8:0]          x1_o,
  output logic [7:0]          y1_o,
  output logic [8:0]          x2_o,
  output logic [7:0]          y2_o,
  output logic [8:0]          op_width_o,
  output logic [7:0]          op_height_o,
  output logic [ADDR_W:0]     queue_count_o,
  output logic                idle_o
);

  localparam int              CNT_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  typedef struct packed {
    logic       op;
    logic       fill_value;
    logic [8:0] x1;
    logic [7:0] y1;
    logic [8:0] x2;
    logic [7:0] y2;
    logic [8:0] w;
    logic [7:0] h;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_ACK  = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  entry_t            mem_q [DEPTH];
  entry_t            in_s;
  entry_t            head_s;
  entry_t            op_q, op_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q;
  logic              start_fill_q, start_fill_d;
  logic              start_blit_q, start_blit_d;
  logic              idle_q, idle_d;
  logic              push_s;
  logic              pop_s;

  assign in_s   = {cmd_if.cmd_op, cmd_if.cmd_fill_value, cmd_if.cmd_x1, cmd_if.cmd_y1,
                   cmd_if.cmd_x2, cmd_if.cmd_y2, cmd_if.cmd_w, cmd_if.cmd_h};
  assign head_s = mem_q[rd_ptr_q];
  // ready_q mirrors (count_q != DEPTH), so a full queue refuses a push even when popping
  assign push_s = cmd_if.cmd_valid & ready_q;
  assign pop_s  = (state_q == S_IDLE) && (count_q != '0);

  // FIFO pointer and occupancy next-state; flush beats a simultaneous push
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
        2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Sequencer next-state, operand capture and start pulse generation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    start_fill_d = 1'b0;
    start_blit_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pop_s) begin
          op_d    = head_s;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        start_fill_d = ~op_q.op;
        start_blit_d = op_q.op;
        cnt_d        = '0;
        state_d      = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (engine_busy_i) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_d == CNT_W'(ACK_TIMEOUT)) begin
          // engine never went busy: treat as a zero-area op that already finished
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_DONE: begin
        if (!engine_busy_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    idle_d = (state_d == S_IDLE) && (count_d == '0);
  end

  // Command storage; contents are qualified by the pointers so no reset is needed
  always_ff @(posedge clk) begin
    if (push_s && !flush_i) begin
      mem_q[wr_ptr_q] <= in_s;
    end
  end

  // Sequencer, FIFO control and registered output state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cnt_q        <= '0;
      op_q         <= '0;
      start_fill_q <= 1'b0;
      start_blit_q <= 1'b0;
      idle_q       <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      start_fill_q <= start_fill_d;
      start_blit_q <= start_blit_d;
      idle_q       <= idle_d;
      ready_q      <= (count_d != FULL_CNT);
    end
  end

  assign cmd_if.cmd_ready = ready_q;
  assign start_fill_o     = start_fill_q;
  assign start_blit_o     = start_blit_q;
  assign fill_value_o     = op_q.fill_value;
  assign x1_o             = op_q.x1;
  assign y1_o             = op_q.y1;
  assign x2_o             = op_q.x2;
  assign y2_o             = op_q.y2;
  assign op_width_o       = op_q.w;
  assign op_height_o      = op_q.h;
  assign queue_count_o    = count_q;
  assign idle_o           = idle_q;

endmodule

// File: tb/tb_gfx_cmd_scheduler.sv
// Directed self-checking bench for gfx_cmd_scheduler: reset, single fill, queueing,
// full-queue refusal, ack timeout and flush, with hand-computed expectations.
module tb_gfx_cmd_scheduler;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       engine_busy;
  logic       start_fill;
  logic       start_blit;
  logic       fill_value;
  logic [8:0] x1, x2, w;
  logic [7:0] y1, y2, h;
  logic [2:0] queue_count;
  logic       idle;
  logic       prev_start = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int log_x1[$];
  int log_cyc[$];
  int log_w[$];
  int log_op[$];

  gfx_cmd_scheduler_if cmd_if ();

  gfx_cmd_scheduler #(.DEPTH(4), .ADDR_W(2), .ACK_TIMEOUT(15)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_if        (cmd_if),
    .flush_i       (flush),
    .engine_busy_i (engine_busy),
    .start_fill_o  (start_fill),
    .start_blit_o  (start_blit),
    .fill_value_o  (fill_value),
    .x1_o          (x1),
    .y1_o          (y1),
    .x2_o          (x2),
    .y2_o          (y2),
    .op_width_o    (w),
    .op_height_o   (h),
    .queue_count_o (queue_count),
    .idle_o        (idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Start pulses must be one-hot and one cycle wide; log each issue in order
  always @(negedge clk) begin
    if (start_fill || start_blit) begin
      check_eq("start_onehot", 64'(start_fill & start_blit), 64'd0);
      check_eq("start_width", 64'(prev_start), 64'd0);
      log_x1.push_back(int'(x1));
      log_cyc.push_back(cyc);
      log_w.push_back(int'(w));
      log_op.push_back(int'(start_blit));
    end
    prev_start <= start_fill | start_blit;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic op, input logic v, input int ax1, input int ay1,
                         input int ax2, input int ay2, input int aw, input int ah);
    cmd_if.cmd_op         = op;
    cmd_if.cmd_fill_value = v;
    cmd_if.cmd_x1         = 9'(ax1);
    cmd_if.cmd_y1         = 8'(ay1);
    cmd_if.cmd_x2         = 9'(ax2);
    cmd_if.cmd_y2         = 8'(ay2);
    cmd_if.cmd_w          = 9'(aw);
    cmd_if.cmd_h          = 8'(ah);
  endtask

  // Present a command and hold it until the edge that accepts it
  task automatic push(input logic op, input logic v, input int ax1, input int ay1,
                      input int ax2, input int ay2, input int aw, input int ah);
    int k;
    set_cmd(op, v, ax1, ay1, ax2, ay2, aw, ah);
    cmd_if.cmd_valid = 1'b1;
    k = 0;
    while (!cmd_if.cmd_ready && k < 200) begin
      tick();
      k++;
    end
    check_eq("push_accept_bound", 64'(k < 200), 64'd1);
    tick();
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    int k;
    k = 0;
    while (!idle && k < max_cycles) begin
      tick();
      k++;
    end
    check_eq(tag, 64'(idle), 64'd1);
  endtask

  task automatic clear_log();
    log_x1.delete();
    log_cyc.delete();
    log_w.delete();
    log_op.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n            = 1'b0;
    flush            = 1'b0;
    engine_busy      = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    set_cmd(1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;

    // reset state: every output low
    check_eq("rst_count", 64'(queue_count), 64'd0);
    check_eq("rst_ready", 64'(cmd_if.cmd_ready), 64'd0);
    check_eq("rst_start", 64'({start_fill, start_blit}), 64'd0);
    check_eq("rst_idle", 64'(idle), 64'd0);
    check_eq("rst_x1", 64'(x1), 64'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check_eq("post_rst_ready", 64'(cmd_if.cmd_ready), 64'd1);
    check_eq("post_rst_idle", 64'(idle), 64'd1);
    check_eq("post_rst_count", 64'(queue_count), 64'd0);

    // single fill: pop at T+1, start pulse visible after T+2
    push(1'b0, 1'b1, 20, 40, 100, 100, 0, 0);
    check_eq("t2_count_push", 64'(queue_count), 64'd1);
    check_eq("t2_idle_push", 64'(idle), 64'd0);
    check_eq("t2_no_start_t", 64'(start_fill), 64'd0);
    tick();
    check_eq("t2_count_pop", 64'(queue_count), 64'd0);
    check_eq("t2_no_start_t1", 64'(start_fill), 64'd0);
    tick();
    check_eq("t2_start_fill", 64'(start_fill), 64'd1);
    check_eq("t2_start_blit", 64'(start_blit), 64'd0);
    check_eq("t2_x1", 64'(x1), 64'd20);
    check_eq("t2_y1", 64'(y1), 64'd40);
    check_eq("t2_x2", 64'(x2), 64'd100);
    check_eq("t2_y2", 64'(y2), 64'd100);
    check_eq("t2_fill_value", 64'(fill_value), 64'd1);
    engine_busy = 1'b1;
    tick();
    check_eq("t2_pulse_end", 64'(start_fill), 64'd0);
    repeat (3) tick();
    check_eq("t2_hold_x1", 64'(x1), 64'd20);
    check_eq("t2_hold_y2", 64'(y2), 64'd100);
    check_eq("t2_busy_not_idle", 64'(idle), 64'd0);
    engine_busy = 1'b0;
    tick();
    check_eq("t2_idle_after", 64'(idle), 64'd1);

    // reset while a start pulse is on the outputs clears it asynchronously
    push(1'b0, 1'b1, 7, 7, 7, 7, 0, 0);
    tick();
    tick();
    check_eq("t1_pre_start", 64'(start_fill), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t1_async_start", 64'(start_fill), 64'd0);
    check_eq("t1_async_x1", 64'(x1), 64'd0);
    check_eq("t1_async_fv", 64'(fill_value), 64'd0);
    check_eq("t1_async_count", 64'(queue_count), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("t1_ready_release", 64'(cmd_if.cmd_ready), 64'd1);
    check_eq("t1_idle_release", 64'(idle), 64'd1);
    clear_log();

    // back-to-back while the engine stays busy: one in flight, the rest queued
    engine_busy = 1'b1;
    push(1'b0, 1'b0, 1, 1, 1, 1, 0, 0);
    push(1'b0, 1'b0, 2, 2, 2, 2, 0, 0);
    push(1'b0, 1'b0, 3, 3, 3, 3, 0, 0);
    push(1'b1, 1'b0, 4, 4, 40, 40, 30, 20);
    check_eq("t3_count3", 64'(queue_count), 64'd3);
    check_eq("t3_ready3", 64'(cmd_if.cmd_ready), 64'd1);
    push(1'b0, 1'b0, 5, 5, 5, 5, 0, 0);
    check_eq("t3_count4", 64'(queue_count), 64'd4);
    check_eq("t3_ready_full", 64'(cmd_if.cmd_ready), 64'd0);
    repeat (5) tick();
    check_eq("t3_single_start", 64'(log_x1.size()), 64'd1);

    // full queue: a push offered in the same cycle as a pop is refused
    set_cmd(1'b0, 1'b0, 6, 6, 6, 6, 0, 0);
    cmd_if.cmd_valid = 1'b1;
    engine_busy      = 1'b0;
    tick();
    check_eq("t4_count_full", 64'(queue_count), 64'd4);
    check_eq("t4_ready_full", 64'(cmd_if.cmd_ready), 64'd0);
    tick();
    cmd_if.cmd_valid = 1'b0;
    check_eq("t4_count_after_pop", 64'(queue_count), 64'd3);
    check_eq("t4_no_early_start", 64'({start_fill, start_blit}), 64'd0);
    tick();
    check_eq("t4_next_start", 64'(start_fill), 64'd1);
    check_eq("t4_next_x1", 64'(x1), 64'd2);

    // engine never goes busy: each op retires by timeout (15 WAIT_ACK + IDLE + ISSUE = 17)
    wait_idle("t5_drain_idle", 300);
    check_eq("t5_start_total", 64'(log_x1.size()), 64'd5);
    if (log_x1.size() == 5) begin
      check_eq("t5_order0", 64'(log_x1[0]), 64'd1);
      check_eq("t5_order1", 64'(log_x1[1]), 64'd2);
      check_eq("t5_order2", 64'(log_x1[2]), 64'd3);
      check_eq("t5_order3", 64'(log_x1[3]), 64'd4);
      check_eq("t5_order4", 64'(log_x1[4]), 64'd5);
      check_eq("t5_blit_op", 64'(log_op[3]), 64'd1);
      check_eq("t5_blit_w", 64'(log_w[3]), 64'd30);
      check_eq("t5_gap_fill", 64'(log_cyc[2] - log_cyc[1]), 64'd17);
      check_eq("t5_gap_blit", 64'(log_cyc[4] - log_cyc[3]), 64'd17);
    end
    check_eq("t5_count_empty", 64'(queue_count), 64'd0);
    clear_log();

    // flush with 3 queued and 1 in flight, push in the same cycle is dropped
    engine_busy = 1'b1;
    push(1'b0, 1'b1, 10, 10, 10, 10, 0, 0);
    push(1'b0, 1'b1, 11, 11, 11, 11, 0, 0);
    push(1'b0, 1'b1, 12, 12, 12, 12, 0, 0);
    push(1'b0, 1'b1, 13, 13, 13, 13, 0, 0);
    check_eq("t6_count_pre", 64'(queue_count), 64'd3);
    set_cmd(1'b0, 1'b1, 14, 14, 14, 14, 0, 0);
    cmd_if.cmd_valid = 1'b1;
    flush            = 1'b1;
    tick();
    cmd_if.cmd_valid = 1'b0;
    flush            = 1'b0;
    check_eq("t6_count_flush", 64'(queue_count), 64'd0);
    check_eq("t6_ready_flush", 64'(cmd_if.cmd_ready), 64'd1);
    repeat (4) tick();
    check_eq("t6_inflight_hold", 64'(x1), 64'd10);
    check_eq("t6_busy_not_idle", 64'(idle), 64'd0);
    engine_busy = 1'b0;
    wait_idle("t6_idle", 10);
    repeat (30) tick();
    check_eq("t6_start_total", 64'(log_x1.size()), 64'd1);
    check_eq("t6_count_end", 64'(queue_count), 64'd0);
    check_eq("t6_idle_end", 64'(idle), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
